seg7_monitor: RTL and testbench

Receive-side checker for the counter/7-segment display path. It samples a gfedcba segment pattern, decodes it back to a hex digit, and validates the digit against the counter modulus. It tracks successive digits, infers count direction, and flags sequence breaks. It is used as a self-check monitor on the display bus and as the decode end of the segment interface.

---
 rtl/seg7_monitor.sv | 139 +++++++++++++
 tb/tb_seg7_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_monitor.sv
// Receive-side monitor for a gfedcba segment bus: decodes each sampled pattern back to a
// hex digit, infers the counting direction and flags illegal patterns and sequence breaks.
module seg7_monitor #(
   parameter int unsigned MODULO = 6,
   parameter int unsigned ERR_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seg_valid,
   input  logic [6:0]       segs,
   output logic [3:0]       digit,
   output logic             digit_ok,
   output logic             dir_out,
   output logic             locked,
   output logic             seq_err,
   output logic             invalid_pat,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [3:0] MaxVal = 4'(MODULO - 1);

   typedef enum logic [1:0] {StIdle, StFirst, StLocked} state_e;

   state_e           state_q, state_d;
   logic [3:0]       last_q, last_d;
   logic             dir_q, dir_d;
   logic             seq_err_q, seq_err_d;
   logic             inv_q, inv_d;
   logic [ERR_W-1:0] err_q, err_d;

   logic       hit, legal, bump;
   logic [3:0] dec_val, inc, dec, fwd, bwd;

   always_comb begin
      hit     = 1'b1;
      dec_val = 4'h0;
      case (segs)
         7'b0111111: dec_val = 4'h0;
         7'b0000110: dec_val = 4'h1;
         7'b1011011: dec_val = 4'h2;
         7'b1001111: dec_val = 4'h3;
         7'b1100110: dec_val = 4'h4;
         7'b1101101: dec_val = 4'h5;
         7'b1111101: dec_val = 4'h6;
         7'b0000111: dec_val = 4'h7;
         7'b1111111: dec_val = 4'h8;
         7'b1101111: dec_val = 4'h9;
         7'b1110111: dec_val = 4'ha;
         7'b1111100: dec_val = 4'hb;
         7'b0111001: dec_val = 4'hc;
         7'b1011110: dec_val = 4'hd;
         7'b1111001: dec_val = 4'he;
         7'b1110001: dec_val = 4'hf;
         default:    hit     = 1'b0;
      endcase
   end

   assign legal = hit && ({1'b0, dec_val} < 5'(MODULO));
   assign inc   = (last_q == MaxVal) ? 4'h0 : last_q + 4'h1;
   assign dec   = (last_q == 4'h0) ? MaxVal : last_q - 4'h1;
   // With MODULO = 2 fwd == bwd, so the forward (up) reading always wins.
   assign fwd   = dir_q ? dec : inc;
   assign bwd   = dir_q ? inc : dec;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         last_q    <= 4'h0;
         dir_q     <= 1'b0;
         seq_err_q <= 1'b0;
         inv_q     <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         dir_q     <= dir_d;
         seq_err_q <= seq_err_d;
         inv_q     <= inv_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      dir_d     = dir_q;
      seq_err_d = 1'b0;
      inv_d     = 1'b0;
      err_d     = err_q;
      bump      = 1'b0;
      if (seg_valid) begin
         if (!legal) begin
            inv_d   = 1'b1;
            bump    = 1'b1;
            state_d = StIdle;
         end else begin
            last_d = dec_val;
            unique case (state_q)
               StIdle: state_d = StFirst;
               StFirst: begin
                  if (dec_val != last_q) begin
                     if (dec_val == inc) begin
                        dir_d   = 1'b0;
                        state_d = StLocked;
                     end else if (dec_val == dec) begin
                        dir_d   = 1'b1;
                        state_d = StLocked;
                     end
                  end
               end
               StLocked: begin
                  if (dec_val != last_q && dec_val != fwd) begin
                     if (dec_val == bwd) begin
                        dir_d = ~dir_q;
                     end else begin
                        seq_err_d = 1'b1;
                        bump      = 1'b1;
                        state_d   = StFirst;
                     end
                  end
               end
               default: state_d = StIdle;
            endcase
         end
      end
      if (bump && !(&err_q)) err_d = err_q + ERR_W'(1);
   end

   always_comb begin
      digit       = last_q;
      digit_ok    = (state_q != StIdle);
      locked      = (state_q == StLocked);
      dir_out     = dir_q;
      seq_err     = seq_err_q;
      invalid_pat = inv_q;
      err_count   = err_q;
   end

endmodule

// File: tb/tb_seg7_monitor.sv
// Bench for seg7_monitor: directed plan followed by random traffic, checked against a
// table-lookup model using modular arithmetic on two instances (8-bit and 2-bit counters).
module tb_seg7_monitor;

   localparam int unsigned M = 6;

   logic       clk = 1'b0;
   logic       reset, seg_valid;
   logic [6:0] segs;

   logic [3:0] digit, digit_s;
   logic       digit_ok, dir_out, locked, seq_err, invalid_pat;
   logic       digit_ok_s, dir_out_s, locked_s, seq_err_s, invalid_pat_s;
   logic [7:0] err_count;
   logic [1:0] err_count_s;

   int checks = 0;
   int errors = 0;

   logic [6:0] tbl [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                            7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                            7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

   // Reference state: ok = a digit is held, locked/dir = sequence tracking, events unsaturated.
   int m_last, m_events;
   bit m_ok, m_locked, m_dir, m_seq, m_inv;

   always #5 clk = ~clk;

   seg7_monitor #(.MODULO(M), .ERR_W(8)) dut (
      .clk(clk), .reset(reset), .seg_valid(seg_valid), .segs(segs),
      .digit(digit), .digit_ok(digit_ok), .dir_out(dir_out), .locked(locked),
      .seq_err(seq_err), .invalid_pat(invalid_pat), .err_count(err_count)
   );

   seg7_monitor #(.MODULO(M), .ERR_W(2)) dut_sat (
      .clk(clk), .reset(reset), .seg_valid(seg_valid), .segs(segs),
      .digit(digit_s), .digit_ok(digit_ok_s), .dir_out(dir_out_s), .locked(locked_s),
      .seq_err(seq_err_s), .invalid_pat(invalid_pat_s), .err_count(err_count_s)
   );

   function automatic int lookup(logic [6:0] p);
      for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
      return -1;
   endfunction

   task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic model(bit r, bit v, logic [6:0] p);
      int val, up, dn;
      m_seq = 0;
      m_inv = 0;
      if (r) begin
         m_last = 0; m_events = 0; m_ok = 0; m_locked = 0; m_dir = 0;
      end else if (v) begin
         val = lookup(p);
         if (val < 0 || val >= int'(M)) begin
            m_inv = 1; m_events++; m_ok = 0; m_locked = 0;
         end else begin
            up = (m_last + 1) % M;
            dn = (m_last + M - 1) % M;
            if (m_ok && !m_locked) begin
               if (val == m_last) ;
               else if (val == up) begin m_locked = 1; m_dir = 0; end
               else if (val == dn) begin m_locked = 1; m_dir = 1; end
            end else if (m_locked && val != m_last) begin
               if (val == (m_dir ? dn : up)) ;
               else if (val == (m_dir ? up : dn)) m_dir = !m_dir;
               else begin m_seq = 1; m_events++; m_locked = 0; end
            end
            m_last = val;
            m_ok   = 1;
         end
      end
   endtask

   task automatic compare_all();
      check("digit", 8'(digit), 8'(m_last));
      check("digit_ok", 8'(digit_ok), 8'(m_ok));
      check("dir_out", 8'(dir_out), 8'(m_dir));
      check("locked", 8'(locked), 8'(m_locked));
      check("seq_err", 8'(seq_err), 8'(m_seq));
      check("invalid_pat", 8'(invalid_pat), 8'(m_inv));
      check("err_count", err_count, 8'((m_events > 255) ? 255 : m_events));
      check("sat_digit", 8'(digit_s), 8'(m_last));
      check("sat_locked", 8'(locked_s), 8'(m_locked));
      check("sat_err_count", 8'(err_count_s), 8'((m_events > 3) ? 3 : m_events));
   endtask

   task automatic apply(bit r, bit v, logic [6:0] p);
      @(negedge clk);
      reset     = r;
      seg_valid = v;
      segs      = p;
      @(posedge clk);
      model(r, v, p);
      #1;
      compare_all();
   endtask

   task automatic sample(int d);
      apply(0, 1, tbl[d]);
   endtask

   initial begin
      int r, k, nxt;
      logic [6:0] p;
      reset = 1'b1; seg_valid = 1'b0; segs = 7'h0;
      m_last = 0; m_events = 0; m_ok = 0; m_locked = 0; m_dir = 0; m_seq = 0; m_inv = 0;

      // Reset state
      apply(1, 0, 7'h0);
      check("rst_err_count", err_count, 8'd0);

      // Up count with wrap
      sample(0); sample(1);
      check("t1_locked", 8'(locked), 8'd1);
      check("t1_dir", 8'(dir_out), 8'd0);
      for (int i = 2; i < 6; i++) sample(i);
      sample(0);
      check("t1_wrap_seq", 8'(seq_err), 8'd0);
      check("t1_err", err_count, 8'd0);

      // Down count with repeat
      apply(1, 0, 7'h0);
      sample(0); sample(5);
      check("t2_locked", 8'(locked), 8'd1);
      check("t2_dir", 8'(dir_out), 8'd1);
      sample(4); sample(4); sample(3);
      check("t2_digit", 8'(digit), 8'd3);
      check("t2_err", err_count, 8'd0);

      // Sequence break then relock
      apply(1, 0, 7'h0);
      sample(0); sample(1); sample(2); sample(3); sample(1);
      check("t3_seq", 8'(seq_err), 8'd1);
      check("t3_err", err_count, 8'd1);
      check("t3_unlocked", 8'(locked), 8'd0);
      sample(2);
      check("t3_relock", 8'(locked), 8'd1);
      check("t3_err2", err_count, 8'd1);

      // Direction switch
      sample(3); sample(2);
      check("t4_dir", 8'(dir_out), 8'd1);
      check("t4_locked", 8'(locked), 8'd1);
      sample(1);
      check("t4_seq", 8'(seq_err), 8'd0);

      // Illegal pattern and out-of-modulus digit
      apply(1, 0, 7'h0);
      sample(0); sample(1); sample(2);
      apply(0, 1, 7'b1111110);
      check("t5_inv", 8'(invalid_pat), 8'd1);
      check("t5_ok", 8'(digit_ok), 8'd0);
      apply(0, 1, 7'b1111101);
      check("t5_inv2", 8'(invalid_pat), 8'd1);
      check("t5_err", err_count, 8'd2);
      check("t5_digit", 8'(digit), 8'd2);
      apply(0, 0, 7'b1111101);
      check("t5_pulse_drop", 8'(invalid_pat), 8'd0);

      // Saturation, then reset beating a valid sample
      for (int i = 0; i < 5; i++) apply(0, 1, 7'b0000000);
      check("t6_sat", 8'(err_count_s), 8'd3);
      apply(1, 1, tbl[3]);
      check("t6_digit", 8'(digit), 8'd0);
      check("t6_ok", 8'(digit_ok), 8'd0);
      check("t6_err", err_count, 8'd0);

      // Random traffic biased toward legal steps so locks form and break
      for (int n = 0; n < 800; n++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            apply(1, ($urandom_range(0, 1) == 1), tbl[$urandom_range(0, 15)]);
         end else if (r < 12) begin
            apply(0, 0, 7'($urandom));
         end else if (r < 20) begin
            if ($urandom_range(0, 1) == 1) p = 7'($urandom);
            else p = tbl[$urandom_range(M, 15)];
            apply(0, 1, p);
         end else begin
            k = $urandom_range(0, 9);
            if (k < 4) nxt = (m_last + 1) % M;
            else if (k < 7) nxt = (m_last + M - 1) % M;
            else if (k < 8) nxt = m_last;
            else nxt = $urandom_range(0, M - 1);
            sample(nxt);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
